// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode constants and control bundle shared by the pipeline control unit
package ctrl_pkg;

  localparam int unsigned OP_BEQ   = 7;
  localparam int unsigned OP_LOAD  = 9;
  localparam int unsigned OP_STORE = 10;
  localparam int unsigned OP_JUMP  = 11;

  typedef struct packed {
    logic reg_write;
    logic alu_src;
    logic branch;
    logic load;
    logic mem_write;
    logic jump;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_control_unit_if.sv
// rtl/pipe_control_unit_if.sv - ID-side inputs and stage-control outputs of the pipeline control unit
interface pipe_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int REG_AW   = 3
);

  logic                id_valid;
  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_AW-1:0]   id_rs1;
  logic [REG_AW-1:0]   id_rs2;
  logic [REG_AW-1:0]   id_rd;
  logic                ex_cmp_eq;
  logic                stall_ext;

  logic                ex_alu_src;
  logic                ex_branch;
  logic                mem_load;
  logic                mem_write;
  logic                wb_reg_write;
  logic                wb_load;
  logic [REG_AW-1:0]   wb_rd;
  logic                jump_id;
  logic                branch_taken;
  logic                stall_if;
  logic                flush_ifid;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_cmp_eq, stall_ext,
    input  ex_alu_src, ex_branch, mem_load, mem_write, wb_reg_write, wb_load,
           wb_rd, jump_id, branch_taken, stall_if, flush_ifid
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_cmp_eq, stall_ext,
    output ex_alu_src, ex_branch, mem_load, mem_write, wb_reg_write, wb_load,
           wb_rd, jump_id, branch_taken, stall_if, flush_ifid
  );

endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control-bundle decoder with source-register usage flags
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int RTYPE_MAX = 6
) (
  input  logic                valid,
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                use_rs1,
  output logic                use_rs2
);

  localparam logic [OPCODE_W-1:0] RTYPE_LIM = OPCODE_W'(RTYPE_MAX);
  localparam logic [OPCODE_W-1:0] BEQ_OP    = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] LOAD_OP   = OPCODE_W'(OP_LOAD);
  localparam logic [OPCODE_W-1:0] STORE_OP  = OPCODE_W'(OP_STORE);
  localparam logic [OPCODE_W-1:0] JUMP_OP   = OPCODE_W'(OP_JUMP);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (valid) begin
      // R-type range takes precedence should RTYPE_MAX ever overlap a named opcode
      if (opcode <= RTYPE_LIM) begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end else if (opcode == BEQ_OP) begin
        ctrl.alu_src = 1'b1;
        ctrl.branch  = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end else if (opcode == LOAD_OP) begin
        ctrl.alu_src   = 1'b1;
        ctrl.load      = 1'b1;
        ctrl.reg_write = 1'b1;
        use_rs1        = 1'b1;
      end else if (opcode == STORE_OP) begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
      end else if (opcode == JUMP_OP) begin
        ctrl.jump = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - pipelined control: ID decode, ID/EX, EX/MEM, MEM/WB control registers and hazard/redirect logic
module pipe_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int REG_AW    = 3,
  parameter int RTYPE_MAX = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_control_unit_if.slave   bus
);

  ctrl_t dec;
  logic  use_rs1;
  logic  use_rs2;

  ctrl_decode #(
    .OPCODE_W  (OPCODE_W),
    .RTYPE_MAX (RTYPE_MAX)
  ) u_decode (
    .valid   (bus.id_valid),
    .opcode  (bus.id_opcode),
    .ctrl    (dec),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2)
  );

  logic              idex_alu_src;
  logic              idex_branch;
  logic              idex_load;
  logic              idex_mem_write;
  logic              idex_reg_write;
  logic [REG_AW-1:0] idex_rd;

  logic              exmem_load;
  logic              exmem_mem_write;
  logic              exmem_reg_write;
  logic [REG_AW-1:0] exmem_rd;

  logic              memwb_load;
  logic              memwb_reg_write;
  logic [REG_AW-1:0] memwb_rd;

  logic load_use;
  logic branch_take;
  logic stall_hold;
  logic jump_take;
  logic squash;

  assign load_use = idex_load && (idex_rd != '0) &&
                    ((use_rs1 && (bus.id_rs1 == idex_rd)) ||
                     (use_rs2 && (bus.id_rs2 == idex_rd)));

  // Redirect and stall requests are masked during reset so that they follow the bubble-filled stages
  assign branch_take = !rst && !bus.stall_ext && idex_branch && bus.ex_cmp_eq;
  assign stall_hold  = !rst && (bus.stall_ext || (load_use && !branch_take));
  assign jump_take   = !rst && dec.jump && !stall_hold && !branch_take;

  // A resolved jump has no further work, so it also enters EX as a bubble
  assign squash = branch_take || load_use || dec.jump;

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_alu_src    <= 1'b0;
      idex_branch     <= 1'b0;
      idex_load       <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_reg_write  <= 1'b0;
      idex_rd         <= '0;
      exmem_load      <= 1'b0;
      exmem_mem_write <= 1'b0;
      exmem_reg_write <= 1'b0;
      exmem_rd        <= '0;
      memwb_load      <= 1'b0;
      memwb_reg_write <= 1'b0;
      memwb_rd        <= '0;
    end else if (!bus.stall_ext) begin
      if (squash) begin
        idex_alu_src   <= 1'b0;
        idex_branch    <= 1'b0;
        idex_load      <= 1'b0;
        idex_mem_write <= 1'b0;
        idex_reg_write <= 1'b0;
        idex_rd        <= '0;
      end else begin
        idex_alu_src   <= dec.alu_src;
        idex_branch    <= dec.branch;
        idex_load      <= dec.load;
        idex_mem_write <= dec.mem_write;
        idex_reg_write <= dec.reg_write;
        idex_rd        <= dec.reg_write ? bus.id_rd : '0;
      end

      exmem_load      <= idex_load;
      exmem_mem_write <= idex_mem_write;
      exmem_reg_write <= idex_reg_write;
      exmem_rd        <= idex_rd;

      // Register 0 is never a write-back target
      memwb_load      <= exmem_load;
      memwb_reg_write <= exmem_reg_write && (exmem_rd != '0);
      memwb_rd        <= exmem_rd;
    end
  end

  assign bus.ex_alu_src   = idex_alu_src;
  assign bus.ex_branch    = idex_branch;
  assign bus.mem_load     = exmem_load;
  assign bus.mem_write    = exmem_mem_write;
  assign bus.wb_reg_write = memwb_reg_write;
  assign bus.wb_load      = memwb_load;
  assign bus.wb_rd        = memwb_rd;
  assign bus.jump_id      = jump_take;
  assign bus.branch_taken = branch_take;
  assign bus.stall_if     = stall_hold;
  assign bus.flush_ifid   = branch_take || jump_take;

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - randomized bench comparing the control unit with an instruction-level pipeline model
module tb_pipe_control_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_control_unit_if #(.OPCODE_W(4), .REG_AW(3)) bus ();

  pipe_control_unit #(.OPCODE_W(4), .REG_AW(3), .RTYPE_MAX(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instructions in flight, index 0 = EX, 1 = MEM, 2 = WB
  typedef struct {
    bit v;
    int op;
    int rd;
  } slot_t;
  slot_t st[3];

  bit c_v;
  int c_op, c_rs1, c_rs2, c_rd;
  bit cmp, sx;
  int sx_left;

  function automatic bit is_r(int op);     return op <= 6; endfunction
  function automatic bit is_known(int op); return is_r(op) || op == 7 || op == 9 || op == 10 || op == 11; endfunction
  function automatic bit writes(int op);   return is_r(op) || op == 9; endfunction
  function automatic bit uses1(int op);    return is_r(op) || op == 7 || op == 9 || op == 10; endfunction
  function automatic bit uses2(int op);    return is_r(op) || op == 7 || op == 10; endfunction

  bit e_alu, e_br, e_mld, e_mwr, e_wbw, e_wbl, e_bt, e_lu, e_sif, e_jmp, e_fl;
  int e_rd;

  task automatic new_instr();
    int r;
    c_v = ($urandom_range(0, 7) != 0);
    r   = $urandom_range(0, 15);
    if (r <= 4)       c_op = $urandom_range(0, 6);
    else if (r <= 6)  c_op = 7;
    else if (r <= 9)  c_op = 9;
    else if (r <= 11) c_op = 10;
    else if (r == 12) c_op = 11;
    else if (r == 13) c_op = 8;
    else              c_op = $urandom_range(12, 15);
    c_rs1 = $urandom_range(0, 3);
    c_rs2 = $urandom_range(0, 3);
    c_rd  = $urandom_range(0, 3);
  endtask

  task automatic drive();
    bus.id_valid  = c_v;
    bus.id_opcode = 4'(c_op);
    bus.id_rs1    = 3'(c_rs1);
    bus.id_rs2    = 3'(c_rs2);
    bus.id_rd     = 3'(c_rd);
    bus.ex_cmp_eq = cmp;
    bus.stall_ext = sx;
  endtask

  task automatic model_comb();
    e_alu = st[0].v && uses1(st[0].op);
    e_br  = st[0].v && st[0].op == 7;
    e_mld = st[1].v && st[1].op == 9;
    e_mwr = st[1].v && st[1].op == 10;
    e_wbw = st[2].v && writes(st[2].op) && st[2].rd != 0;
    e_wbl = st[2].v && st[2].op == 9;
    e_rd  = st[2].rd;
    e_bt  = e_br && cmp && !sx;
    e_lu  = c_v && st[0].v && st[0].op == 9 && st[0].rd != 0 &&
            ((uses1(c_op) && c_rs1 == st[0].rd) || (uses2(c_op) && c_rs2 == st[0].rd));
    e_sif = sx || (e_lu && !e_bt);
    e_jmp = c_v && c_op == 11 && !e_sif && !e_bt;
    e_fl  = e_bt || e_jmp;
  endtask

  task automatic compare_all();
    check("ex_alu_src",   32'(bus.ex_alu_src),   32'(e_alu));
    check("ex_branch",    32'(bus.ex_branch),    32'(e_br));
    check("mem_load",     32'(bus.mem_load),     32'(e_mld));
    check("mem_write",    32'(bus.mem_write),    32'(e_mwr));
    check("wb_reg_write", 32'(bus.wb_reg_write), 32'(e_wbw));
    check("wb_load",      32'(bus.wb_load),      32'(e_wbl));
    if (e_wbw) check("wb_rd", 32'(bus.wb_rd), 32'(e_rd));
    check("jump_id",      32'(bus.jump_id),      32'(e_jmp));
    check("branch_taken", 32'(bus.branch_taken), 32'(e_bt));
    check("stall_if",     32'(bus.stall_if),     32'(e_sif));
    check("flush_ifid",   32'(bus.flush_ifid),   32'(e_fl));
  endtask

  task automatic model_step();
    if (sx) return;
    st[2] = st[1];
    st[1] = st[0];
    if (e_bt || e_lu || !c_v || !is_known(c_op) || c_op == 11) st[0] = '{0, 0, 0};
    else st[0] = '{1, c_op, writes(c_op) ? c_rd : 0};
  endtask

  initial begin
    for (int i = 0; i < 3; i++) st[i] = '{0, 0, 0};
    c_v = 1; c_op = 3; c_rs1 = 1; c_rs2 = 2; c_rd = 5;
    cmp = 0; sx = 0; sx_left = 0;
    rst = 1'b1;
    drive();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      e_alu = 0; e_br = 0; e_mld = 0; e_mwr = 0; e_wbw = 0; e_wbl = 0;
      e_jmp = 0; e_bt = 0; e_sif = 0; e_fl = 0; e_rd = 0;
      compare_all();
      check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    end
    rst = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      drive();
      #1;
      model_comb();
      compare_all();
      @(posedge clk);
      model_step();
      if (!e_sif) begin
        if (e_fl) c_v = 0;
        else new_instr();
      end
      if (sx_left > 0) sx_left--;
      else if ($urandom_range(0, 24) == 0) sx_left = 3;
      sx  = (sx_left > 0);
      cmp = ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Parametrised, pipelined successor to the single-cycle opcode decoder.
- Decodes the ID-stage opcode into control bundles and carries them through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, resolves jump in ID and branch in EX, and drives stall/flush for the fetch stage.
- Sits between the IF/ID register and the datapath stage registers.

Parameters:
- OPCODE_W, 4, opcode width.
- REG_AW, 3, register-address width.
- RTYPE_MAX, 6, highest opcode value decoded as R-type (0..RTYPE_MAX).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  OPCODE_W  opcode in ID.
- id_rs1, id_rs2, id_rd  in  REG_AW each  register fields in ID.
- ex_cmp_eq  in  1  ALU equality result for the EX-stage instruction.
- stall_ext  in  1  external freeze (e.g. memory wait).
- ex_alu_src, ex_branch  out  1 each  EX-stage controls.
- mem_load, mem_write  out  1 each  MEM-stage controls.
- wb_reg_write, wb_load  out  1 each  WB-stage controls (wb_load selects memory data).
- wb_rd  out  REG_AW  write-back destination.
- jump_id  out  1  redirect PC to the jump target this cycle.
- branch_taken  out  1  redirect PC to the branch target this cycle.
- stall_if  out  1  hold PC and IF/ID.
- flush_ifid  out  1  replace IF/ID contents with a bubble next edge.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all stage registers clear to bubble (all controls 0, rd 0), so every registered output is 0. Combinational outputs evaluate to 0 because every stage holds a bubble.
- Decode (combinational, valid only when id_valid=1; otherwise bubble):
  - opcode ≤ RTYPE_MAX: reg_write=1, alu_src=1.
  - OP_BEQ (7): alu_src=1, branch=1.
  - OP_LOAD (9): alu_src=1, load=1, reg_write=1.
  - OP_STORE (10): alu_src=1, mem_write=1, load=0.
  - OP_JUMP (11): jump=1.
  - Any other opcode: bubble (no side effects).
- Source usage:
  - rs1 is used by R-type, BEQ, LOAD and STORE.
  - rs2 is used by R-type, BEQ and STORE.
- Load-use hazard: ID/EX holds a load with rd ≠ 0, and rd equals a used rs1 or rs2 of a valid ID instruction. Response: stall_if=1, a bubble enters ID/EX, and the ID instruction is held. Duration is exactly 1 cycle per hazard.
- Jump: jump_id = decoded jump and no stall_if and no stall_ext and no branch_taken. When jump_id=1, flush_ifid=1. The jump itself enters EX as a bubble.
- Branch: branch_taken = ex_branch & ex_cmp_eq & ~stall_ext. When branch_taken=1:
  - flush_ifid=1.
  - ID/EX loads a bubble, discarding the ID instruction.
  - stall_if and jump_id are suppressed.
  - Total penalty is 2 cycles.
- Priority, highest first: rst > stall_ext > branch_taken > load-use stall > jump_id.
- stall_ext=1: all stage registers hold; stall_if=1; flush_ifid=0; jump_id=0; branch_taken=0.
- Advance: EX/MEM and MEM/WB advance every non-frozen cycle. Latency from ID decode to wb_reg_write is 3 clock edges.
- Register 0 is never written: wb_reg_write is forced to 0 when wb_rd=0.

Decomposition:
- Shared package ctrl_pkg:
  - opcode localparams OP_BEQ, OP_LOAD, OP_STORE, OP_JUMP;
  - ctrl_t struct {reg_write, alu_src, branch, load, mem_write, jump};
  - CTRL_BUBBLE constant.
- One sub-module, ctrl_decode: purely combinational opcode → ctrl_t. The pipeline registers and hazard logic stay in the top module.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1, opcode=3 → all outputs 0. After release, wb_reg_write=1 exactly 3 edges later.
- Load-use: LOAD rd=2, then R-type rs1=2 → stall_if=1 for one cycle, one bubble in EX, R-type reaches WB 4 edges after issue. The same sequence with rd=0 → no stall.
- Branch: BEQ with ex_cmp_eq=1 → branch_taken=1 and flush_ifid=1 for one cycle; the following two instructions never assert wb_reg_write. With ex_cmp_eq=0 → no flush.
- Jump: opcode=11 → jump_id=1 and flush_ifid=1 in the same cycle; no write-back from the jump or the squashed slot.
- Branch vs jump: BEQ taken in EX while JUMP sits in ID → branch_taken=1, jump_id=0.
- stall_ext: assert for 3 cycles mid-stream → outputs frozen, stall_if=1. Release → sequence resumes with no lost or duplicated wb_reg_write. Store (opcode=10) → mem_write=1, mem_load=0.
